// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch stage: requests one word at pc, holds it
// for decode until accepted, then advances pc sequentially or to a branch target.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        pc_src,
   input  logic [31:0] pc_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] pc_out,
   output logic        instr_valid,
   output logic        misalign
);

   localparam logic [1:0] S_RESET_WAIT = 2'd0;
   localparam logic [1:0] S_FETCH      = 2'd1;
   localparam logic [1:0] S_HOLD       = 2'd2;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic        misalign_q, misalign_d;
   logic        accept;

   assign accept = (state_q == S_HOLD) && !stall;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      pc_out_d   = pc_out_q;
      misalign_d = misalign_q;
      case (state_q)
         S_RESET_WAIT: state_d = S_FETCH;
         S_FETCH: begin
            if (imem_ready) begin
               instr_d  = imem_rdata;
               pc_out_d = pc_q;
               state_d  = S_HOLD;
            end
         end
         S_HOLD: begin
            // Branch inputs only matter on the accepting cycle.
            if (accept) begin
               state_d = S_FETCH;
               if (pc_src) begin
                  pc_d = {pc_target[31:2], 2'b00};
                  if (pc_target[1:0] != 2'b00) misalign_d = 1'b1;
               end else begin
                  pc_d = pc_q + 32'd4;
               end
            end
         end
         default: state_d = S_RESET_WAIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_RESET_WAIT;
         pc_q       <= RESET_PC;
         instr_q    <= NOP;
         pc_out_q   <= RESET_PC;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         pc_out_q   <= pc_out_d;
         misalign_q <= misalign_d;
      end
   end

   assign imem_req    = (state_q == S_FETCH);
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign pc_out      = pc_out_q;
   assign instr_valid = (state_q == S_HOLD);
   assign misalign    = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a transaction-level model tracks what fetch
// should expose each cycle, and literal checks pin the key scenarios.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst, stall, pc_src, imem_ready;
   logic [31:0] pc_target, imem_rdata;
   logic        imem_req, instr_valid, misalign;
   logic [31:0] imem_addr, instr, pc_out;

   int checks = 0;
   int errors = 0;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .instr(instr), .pc_out(pc_out),
      .instr_valid(instr_valid), .misalign(misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: "started" = past the one idle cycle after reset; "have" = an
   // instruction is held for decode. A fetch is outstanding when started && !have.
   bit          m_on = 0;
   bit          m_started, m_have, m_mis;
   logic [31:0] m_pc, m_instr, m_pc_out;

   always @(posedge clk) begin
      if (rst) begin
         m_on = 1; m_started = 0; m_have = 0; m_mis = 0;
         m_pc = 32'h0; m_instr = 32'h13; m_pc_out = 32'h0;
      end else if (m_on) begin
         if (!m_started) m_started = 1;
         else if (!m_have) begin
            if (imem_ready) begin m_instr = imem_rdata; m_pc_out = m_pc; m_have = 1; end
         end else if (!stall) begin
            if (pc_src) begin
               m_pc = pc_target & 32'hFFFF_FFFC;
               if (pc_target % 4 != 0) m_mis = 1;
            end else m_pc = m_pc + 32'd4;
            m_have = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_on) begin
         chk("m_req",      {31'b0, imem_req},    {31'b0, m_started && !m_have});
         chk("m_addr",     imem_addr,            m_pc);
         chk("m_valid",    {31'b0, instr_valid}, {31'b0, m_have});
         chk("m_instr",    instr,                m_instr);
         chk("m_pc_out",   pc_out,               m_pc_out);
         chk("m_misalign", {31'b0, misalign},    {31'b0, m_mis});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Complete one fetch immediately and leave the word held.
   task automatic fetch_now(input logic [31:0] data);
      imem_ready = 1; imem_rdata = data;
      tick();
      imem_ready = 0;
   endtask

   task automatic accept(input logic src, input logic [31:0] tgt);
      stall = 0; pc_src = src; pc_target = tgt;
      tick();
      pc_src = 0; pc_target = 32'h0;
   endtask

   initial begin
      rst = 1; stall = 0; pc_src = 0; pc_target = 0; imem_ready = 0; imem_rdata = 0;
      tick(); tick();
      chk("rst_req",   {31'b0, imem_req},    32'd0);
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_instr", instr,                32'h0000_0013);
      chk("rst_pc_out", pc_out,              32'h0);
      rst = 0;
      chk("wait_req",  {31'b0, imem_req},    32'd0);
      tick();
      chk("fetch_req", {31'b0, imem_req},    32'd1);
      chk("fetch_addr", imem_addr,           32'h0);

      // First fetch answered immediately.
      fetch_now(32'h0000_2083);
      chk("first_valid", {31'b0, instr_valid}, 32'd1);
      chk("first_instr", instr,                32'h0000_2083);
      chk("first_pc_out", pc_out,              32'h0);
      accept(0, 0);
      chk("next_addr", imem_addr, 32'h4);

      // Slow memory: request held steady with a foreign pc_src asserted.
      pc_src = 1; pc_target = 32'h0000_0300;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("slow_req",   {31'b0, imem_req},    32'd1);
         chk("slow_addr",  imem_addr,            32'h4);
         chk("slow_valid", {31'b0, instr_valid}, 32'd0);
      end
      pc_src = 0; pc_target = 0;
      fetch_now(32'h0040_0093);

      // Stall with branch inputs and a stray imem_ready: all ignored.
      stall = 1; pc_src = 1; pc_target = 32'h0000_0200;
      imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_instr",  instr,  32'h0040_0093);
         chk("stall_pc_out", pc_out, 32'h4);
      end
      imem_ready = 0;
      accept(0, 0);
      chk("after_stall_addr", imem_addr, 32'h8);

      // Taken branch, aligned.
      fetch_now(32'h0000_0063);
      accept(1, 32'h0000_0100);
      chk("br_addr", imem_addr, 32'h100);
      chk("br_mis",  {31'b0, misalign}, 32'd0);

      // Taken branch, misaligned: low bits dropped, flag sticks.
      fetch_now(32'h0000_0063);
      accept(1, 32'h0000_0102);
      chk("mis_addr", imem_addr, 32'h100);
      chk("mis_flag", {31'b0, misalign}, 32'd1);
      fetch_now(32'h0000_0013);
      accept(0, 0);
      chk("mis_seq_addr", imem_addr, 32'h104);
      chk("mis_sticky",   {31'b0, misalign}, 32'd1);

      // Wrap at top of address space.
      fetch_now(32'h0000_0063);
      accept(1, 32'hFFFF_FFFC);
      chk("top_addr", imem_addr, 32'hFFFF_FFFC);
      fetch_now(32'h1234_5013);
      chk("top_pc_out", pc_out, 32'hFFFF_FFFC);
      accept(0, 0);
      chk("wrap_addr", imem_addr, 32'h0);
      chk("wrap_mis",  {31'b0, misalign}, 32'd1);

      // Reset mid-fetch with a response arriving: abandoned.
      tick();
      rst = 1; imem_ready = 1; imem_rdata = 32'hCAFE_F00D;
      tick();
      imem_ready = 0;
      chk("mid_rst_req",    {31'b0, imem_req},    32'd0);
      chk("mid_rst_valid",  {31'b0, instr_valid}, 32'd0);
      chk("mid_rst_instr",  instr,                32'h0000_0013);
      chk("mid_rst_pc_out", pc_out,               32'h0);
      chk("mid_rst_mis",    {31'b0, misalign},    32'd0);
      chk("mid_rst_addr",   imem_addr,            32'h0);
      rst = 0;
      tick();
      fetch_now(32'h0000_0513);
      chk("post_rst_instr", instr, 32'h0000_0513);
      accept(0, 0);
      chk("post_rst_addr", imem_addr, 32'h4);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
